// File: rtl/ts_intf_pkg.sv
// ts_intf_pkg -- shared constants and types for the ts_intf shared-bus block.
//   ADRS_W_DEF     : default address width
//   RST_ADRS_FILL  : fill bit for the reset address (reset address is all ones
//                    at whatever width the block is built with)
//   adrs_t         : address type at the default width
//   slave_adrs_t   : default slave decode table type (index 1, index 0)
//   SLAVE_ADRS_DEF : default slave decode table {42, 50}
package ts_intf_pkg;

  localparam int ADRS_W_DEF = 8;
  localparam int MAX_SLAVES = 16;

  // The reset address must never appear in a slave table, so that nothing
  // is selected out of reset.
  localparam logic RST_ADRS_FILL = 1'b1;
  localparam logic [ADRS_W_DEF-1:0] RST_ADRS = {ADRS_W_DEF{RST_ADRS_FILL}};

  typedef logic [ADRS_W_DEF-1:0] adrs_t;
  typedef adrs_t [1:0] slave_adrs_t;

  localparam slave_adrs_t SLAVE_ADRS_DEF = {8'd42, 8'd50};

endpackage

// File: rtl/ts_adrs_decode.sv
// ts_adrs_decode -- compares an address against every slave decode address.
//   adrs : address to decode
//   sel  : one bit per slave, high when adrs equals that slave's address
//   hit  : high when at least one slave matches
// Purely combinational; several bits of sel may be high if the table holds
// duplicate entries, which the parent treats as a bus conflict.
module ts_adrs_decode
  import ts_intf_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int ADRS_W     = ADRS_W_DEF,
  parameter logic [NUM_SLAVES-1:0][ADRS_W-1:0] SLAVE_ADRS = SLAVE_ADRS_DEF
) (
  input  logic [ADRS_W-1:0]     adrs,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_cmp
    assign sel[gi] = (adrs == SLAVE_ADRS[gi]);
  end

  assign hit = |sel;

endmodule

// File: rtl/ts_intf.sv
// ts_intf -- logical (non tri-state) model of a shared bus with one master
// and NUM_SLAVES slaves.
//   clk       : clock, all state on rising edge
//   rst       : asynchronous active-high reset
//   m_adrs    : master address
//   m_adrs_we : master address load strobe
//   m_data    : resolved bus data, registered
//   m_data_z  : high when no slave drove the bus on the previous cycle
//   s_data    : per-slave data
//   s_sel     : per-slave select, combinational from the address register
//   conflict  : sticky flag, more than one slave selected at once
//   miss_cnt  : saturating count of address loads that selected no slave
module ts_intf
  import ts_intf_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int ADRS_W     = ADRS_W_DEF,
  parameter logic [NUM_SLAVES-1:0][ADRS_W-1:0] SLAVE_ADRS = SLAVE_ADRS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADRS_W-1:0]     m_adrs,
  input  logic                  m_adrs_we,
  output logic                  m_data,
  output logic                  m_data_z,
  input  logic [NUM_SLAVES-1:0] s_data,
  output logic [NUM_SLAVES-1:0] s_sel,
  output logic                  conflict,
  output logic [7:0]            miss_cnt
);

  localparam logic [ADRS_W-1:0] ADRS_RST = {ADRS_W{RST_ADRS_FILL}};
  localparam logic [7:0]        MISS_MAX = 8'hFF;

  logic [ADRS_W-1:0]     adrs_q;
  logic                  sel_hit;
  logic                  multi_sel;
  logic                  bus_or;
  logic [NUM_SLAVES-1:0] m_match;
  logic                  m_hit;

  // Address register. Reloading the same address leaves adrs_q unchanged,
  // so s_sel cannot glitch on repeated strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adrs_q <= ADRS_RST;
    end else if (m_adrs_we) begin
      adrs_q <= m_adrs;
    end
  end

  ts_adrs_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADRS_W     (ADRS_W),
    .SLAVE_ADRS (SLAVE_ADRS)
  ) u_decode (
    .adrs (adrs_q),
    .sel  (s_sel),
    .hit  (sel_hit)
  );

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_sel = |(s_sel & (s_sel - NUM_SLAVES'(1)));

  // Wired-OR resolution of the slaves that are selected.
  assign bus_or = |(s_data & s_sel);

  // Miss detection looks at the incoming address, not adrs_q, so each
  // strobe is judged on what it is loading.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_miss
    assign m_match[gi] = (m_adrs == SLAVE_ADRS[gi]);
  end
  assign m_hit = |m_match;

  // Registered bus view. A conflict forces the data low rather than
  // returning the OR of contending drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data   <= 1'b0;
      m_data_z <= 1'b1;
      conflict <= 1'b0;
    end else begin
      m_data   <= bus_or & ~multi_sel;
      m_data_z <= ~sel_hit;
      if (multi_sel) begin
        conflict <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt <= 8'd0;
    end else if (m_adrs_we && !m_hit && (miss_cnt != MISS_MAX)) begin
      miss_cnt <= miss_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ts_intf.sv
// tb_ts_intf -- scoreboard bench for ts_intf. Two instances share the same
// stimulus: dut_a uses the default slave table {42,50}, dut_b uses {50,50}
// so that address 50 produces a bus conflict.
module tb_ts_intf;

  logic       clk;
  logic       rst;
  logic [7:0] m_adrs;
  logic       m_adrs_we;
  logic [1:0] s_data;

  logic       a_data, a_z, a_conf;
  logic [1:0] a_sel;
  logic [7:0] a_miss;
  logic       b_data, b_z, b_conf;
  logic [1:0] b_sel;
  logic [7:0] b_miss;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ts_intf dut_a (
    .clk       (clk),
    .rst       (rst),
    .m_adrs    (m_adrs),
    .m_adrs_we (m_adrs_we),
    .m_data    (a_data),
    .m_data_z  (a_z),
    .s_data    (s_data),
    .s_sel     (a_sel),
    .conflict  (a_conf),
    .miss_cnt  (a_miss)
  );

  ts_intf #(
    .NUM_SLAVES (2),
    .ADRS_W     (8),
    .SLAVE_ADRS ({8'd50, 8'd50})
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .m_adrs    (m_adrs),
    .m_adrs_we (m_adrs_we),
    .m_data    (b_data),
    .m_data_z  (b_z),
    .s_data    (s_data),
    .s_sel     (b_sel),
    .conflict  (b_conf),
    .miss_cnt  (b_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         dut;
    string      name;
    logic [1:0] sel;
    logic       data;
    logic       z;
    logic       conf;
    logic [7:0] miss;
  } exp_t;

  exp_t sbq[$];

  task automatic expect_st(input int dut, input int dcyc, input string name,
                           input logic [1:0] sel, input logic data,
                           input logic z, input logic conf,
                           input logic [7:0] miss);
    exp_t e;
    e.cyc  = cyc + dcyc;
    e.dut  = dut;
    e.name = name;
    e.sel  = sel;
    e.data = data;
    e.z    = z;
    e.conf = conf;
    e.miss = miss;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input string field,
                     input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s cyc=%0d got=%0d expected=%0d", name, field, cyc, act, req);
    end
  endtask

  // Monitor: at each falling edge, compare every expectation due this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale expectation due=%0d now=%0d", e.name, e.cyc, cyc);
      end else if (e.dut == 0) begin
        chk(e.name, "a_sel",  int'(a_sel),  int'(e.sel));
        chk(e.name, "a_data", int'(a_data), int'(e.data));
        chk(e.name, "a_z",    int'(a_z),    int'(e.z));
        chk(e.name, "a_conf", int'(a_conf), int'(e.conf));
        chk(e.name, "a_miss", int'(a_miss), int'(e.miss));
        $display("cyc %0d dut_a %s sel=%b data=%b z=%b conf=%b miss=%0d",
                 cyc, e.name, a_sel, a_data, a_z, a_conf, a_miss);
      end else begin
        chk(e.name, "b_sel",  int'(b_sel),  int'(e.sel));
        chk(e.name, "b_data", int'(b_data), int'(e.data));
        chk(e.name, "b_z",    int'(b_z),    int'(e.z));
        chk(e.name, "b_conf", int'(b_conf), int'(e.conf));
        chk(e.name, "b_miss", int'(b_miss), int'(e.miss));
        $display("cyc %0d dut_b %s sel=%b data=%b z=%b conf=%b miss=%0d",
                 cyc, e.name, b_sel, b_data, b_z, b_conf, b_miss);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    m_adrs    = 8'd0;
    m_adrs_we = 1'b0;
    s_data    = 2'b00;
    repeat (3) step();

    // Reset state.
    expect_st(0, 0, "reset", 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    expect_st(1, 0, "reset", 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    rst = 1'b0;
    step();

    // Load 50: slave 0 on dut_a; both slaves (conflict) on dut_b.
    m_adrs = 8'd50; m_adrs_we = 1'b1; s_data = 2'b01;
    expect_st(0, 1, "ld50_sel",  2'b01, 1'b0, 1'b1, 1'b0, 8'd0);
    expect_st(1, 1, "ld50_sel",  2'b11, 1'b0, 1'b1, 1'b0, 8'd0);
    expect_st(0, 2, "ld50_data", 2'b01, 1'b1, 1'b0, 1'b0, 8'd0);
    expect_st(1, 2, "ld50_conf", 2'b11, 1'b0, 1'b0, 1'b1, 8'd0);
    step();
    m_adrs_we = 1'b0;
    step();

    // Load 42: slave 1 on dut_a; a miss on dut_b, conflict stays set.
    m_adrs = 8'd42; m_adrs_we = 1'b1; s_data = 2'b01;
    expect_st(0, 1, "ld42_sel",  2'b10, 1'b1, 1'b0, 1'b0, 8'd0);
    expect_st(1, 1, "ld42_sel",  2'b00, 1'b0, 1'b0, 1'b1, 8'd1);
    expect_st(0, 2, "ld42_d0",   2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_st(1, 2, "ld42_stky", 2'b00, 1'b0, 1'b1, 1'b1, 8'd1);
    step();
    m_adrs_we = 1'b0;
    step();
    s_data = 2'b11;
    expect_st(0, 1, "ld42_d1",   2'b10, 1'b1, 1'b0, 1'b0, 8'd0);
    expect_st(1, 1, "ld42_d1",   2'b00, 1'b0, 1'b1, 1'b1, 8'd1);
    step();

    // Address 7 strobed every cycle for 300 cycles: every strobe is a miss.
    m_adrs = 8'd7; m_adrs_we = 1'b1;
    expect_st(0, 1,   "miss_1",   2'b00, 1'b1, 1'b0, 1'b0, 8'd1);
    expect_st(1, 1,   "miss_1",   2'b00, 1'b0, 1'b1, 1'b1, 8'd2);
    expect_st(0, 2,   "miss_2",   2'b00, 1'b0, 1'b1, 1'b0, 8'd2);
    expect_st(1, 2,   "miss_2",   2'b00, 1'b0, 1'b1, 1'b1, 8'd3);
    expect_st(0, 254, "miss_254", 2'b00, 1'b0, 1'b1, 1'b0, 8'd254);
    expect_st(1, 254, "miss_254", 2'b00, 1'b0, 1'b1, 1'b1, 8'd255);
    expect_st(0, 255, "miss_255", 2'b00, 1'b0, 1'b1, 1'b0, 8'd255);
    expect_st(1, 255, "miss_255", 2'b00, 1'b0, 1'b1, 1'b1, 8'd255);
    expect_st(0, 300, "miss_sat", 2'b00, 1'b0, 1'b1, 1'b0, 8'd255);
    expect_st(1, 300, "miss_sat", 2'b00, 1'b0, 1'b1, 1'b1, 8'd255);
    repeat (300) step();
    m_adrs_we = 1'b0;

    // Select 50 again, then pulse reset between clock edges.
    m_adrs = 8'd50; m_adrs_we = 1'b1;
    expect_st(0, 1, "pre_rst_sel",  2'b01, 1'b0, 1'b1, 1'b0, 8'd255);
    expect_st(1, 1, "pre_rst_sel",  2'b11, 1'b0, 1'b1, 1'b1, 8'd255);
    expect_st(0, 2, "pre_rst_data", 2'b01, 1'b1, 1'b0, 1'b0, 8'd255);
    expect_st(1, 2, "pre_rst_data", 2'b11, 1'b0, 1'b0, 1'b1, 8'd255);
    step();
    m_adrs_we = 1'b0;
    step();
    step();
    expect_st(0, 0, "async_rst", 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    expect_st(1, 0, "async_rst", 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    expect_st(0, 1, "post_rst1", 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    expect_st(1, 1, "post_rst1", 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    expect_st(0, 2, "post_rst2", 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    expect_st(1, 2, "post_rst2", 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    #1 rst = 1'b1;
    #5 rst = 1'b0;
    step();
    step();

    // Reload 50 after reset.
    m_adrs_we = 1'b1;
    expect_st(0, 1, "reload_sel",  2'b01, 1'b0, 1'b1, 1'b0, 8'd0);
    expect_st(1, 1, "reload_sel",  2'b11, 1'b0, 1'b1, 1'b0, 8'd0);
    expect_st(0, 2, "reload_data", 2'b01, 1'b1, 1'b0, 1'b0, 8'd0);
    expect_st(1, 2, "reload_conf", 2'b11, 1'b0, 1'b0, 1'b1, 8'd0);
    step();
    m_adrs_we = 1'b0;
    repeat (3) step();

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ts_intf.md
TS_INTF -- requirements
Module: ts_intf

Interface
REQ-001 Parameter NUM_SLAVES, default 2; number of slave ports on the shared bus, 1..16.
REQ-002 Parameter ADRS_W, default 8; address width.
REQ-003 Parameter SLAVE_ADRS, default {8'd42, 8'd50} (index 1, index 0); packed array giving each slave's decode address.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 m_adrs  input  ADRS_W  master address (master modport output).
REQ-007 m_adrs_we  input  1  master address write strobe; loads m_adrs when high.
REQ-008 m_data  output  1  resolved bus data returned to master.
REQ-009 m_data_z  output  1  high = bus undriven (no slave selected); m_data then reads 0.
REQ-010 s_data  input  NUM_SLAVES  per-slave data (slave modport output).
REQ-011 s_sel  output  NUM_SLAVES  per-slave select; bit i high = slave i drives the bus.
REQ-012 conflict  output  1  sticky: more than one slave selected at once.
REQ-013 miss_cnt  output  8  saturating count of address loads that select no slave.

Function
REQ-014 Address register adrs_q SHALL load m_adrs on a rising edge when m_adrs_we=1; otherwise it holds.
REQ-015 s_sel[i] SHALL be combinational from adrs_q: high iff adrs_q == SLAVE_ADRS[i].
REQ-016 Bus resolution SHALL be the OR over i of (s_data[i] & s_sel[i]), registered once.
REQ-017 m_data and m_data_z SHALL reflect adrs_q and s_data sampled on the previous edge. This gives 2-cycle latency from m_adrs_we to valid m_data.
REQ-018 m_data_z SHALL be registered high when the registered s_sel is all zero; m_data SHALL then be 0.
REQ-019 When popcount(s_sel) > 1, m_data SHALL be forced to 0 and conflict SHALL set.
REQ-020 conflict SHALL stay set until reset.
REQ-021 miss_cnt SHALL increment on each m_adrs_we edge whose m_adrs matches no SLAVE_ADRS entry.
REQ-022 miss_cnt SHALL saturate at 255 and never wrap.
REQ-023 Repeated m_adrs_we with the same address SHALL be accepted each cycle. It causes no glitch on s_sel, and each miss counts.
REQ-024 Simultaneous address change and s_data change: both SHALL be sampled at the same edge, with no priority.

Reset
REQ-025 On rst: adrs_q = all ones, which is an address that must not appear in SLAVE_ADRS. Consequently s_sel = 0.
REQ-026 On rst: m_data = 0, m_data_z = 1, conflict = 0, miss_cnt = 0.
REQ-027 Reset asserted mid-operation SHALL take effect immediately (asynchronous), without waiting for a clock edge.
REQ-028 Normal operation SHALL resume on the first rising edge after rst deasserts.

Structure
REQ-029 Package ts_intf_pkg SHALL hold ADRS_W default, the reset address constant, and the slave-address array typedef.
REQ-030 One sub-module, ts_adrs_decode, SHALL map adrs_q to s_sel and a hit flag.
REQ-031 No tri-state nets inside the block; all resolution is logical.

Verification
REQ-032 Default params, reset released, m_adrs=50 with we=1, s_data=2'b01 -> s_sel=2'b01 after 1 cycle; m_data=1, m_data_z=0 after 2 cycles.
REQ-033 Then m_adrs=42 with we, s_data=2'b01 -> s_sel=2'b10, m_data=0; with s_data=2'b11 -> m_data=1.
REQ-034 m_adrs=7 with we held for 300 cycles -> s_sel=0, m_data_z=1, miss_cnt saturates at 255.
REQ-035 SLAVE_ADRS={50,50}, load 50 -> s_sel=2'b11, m_data=0, conflict=1, and conflict stays 1 after m_adrs changes to 42.
REQ-036 rst pulsed between clock edges while selecting 50 -> outputs immediately take reset values (s_sel=0, m_data_z=1); after release, 50 must be reloaded before it is selected again.
